// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding one FIFO write port.
// Optional full-stall abort enabled by macro FIFO_WR_ARB_TIMEOUT_EN. Rev 1.0
`default_nettype none

module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     fifo_winc,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     fifo_wfull,
  output logic [$clog2(NREQ)-1:0]  cur_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDW-1:0]  r_cur_id, w_cur_id_nxt, w_sel;
  logic [3:0]      r_beat, w_beat_nxt;
  logic            w_req_cur, w_winc, w_found;

  assign w_req_cur  = req[r_cur_id];
  assign w_winc     = (r_state == S_BURST) & w_req_cur & ~fifo_wfull & ~rst;
  assign fifo_winc  = w_winc;
  assign fifo_wdata = req_data[r_cur_id*WIDTH +: WIDTH];
  assign gnt        = r_gnt;
  assign ack        = r_gnt & {NREQ{w_winc}};
  assign cur_id     = r_cur_id;
  assign busy       = (r_state == S_BURST);

  // Round-robin pick: first requester after the last winner.
  always_comb begin
    int w_idx;
    w_sel   = r_cur_id;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_cur_id) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = IDW'(w_idx);
      end
    end
  end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] r_stall, w_stall_nxt;
  logic          r_timeout, w_tmo_nxt;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_cur_id_nxt = r_cur_id;
    w_beat_nxt   = r_beat;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    w_stall_nxt  = '0;
    w_tmo_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt  = S_BURST;
          w_gnt_nxt    = NREQ'(1) << w_sel;
          w_cur_id_nxt = w_sel;
          w_beat_nxt   = 4'd0;
        end
      end
      S_BURST: begin
        if (!w_req_cur) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end else if (fifo_wfull) begin
`ifdef FIFO_WR_ARB_TIMEOUT_EN
          if (r_stall == SW'(TIMEOUT - 1)) begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_tmo_nxt   = 1'b1;
          end else begin
            w_stall_nxt = r_stall + 1'b1;
          end
`endif
        end else begin
          w_beat_nxt = r_beat + 4'd1;
          if (r_beat == 4'(MAX_BURST - 1)) begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_cur_id <= IDW'(NREQ - 1);
      r_beat   <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_cur_id <= w_cur_id_nxt;
      r_beat   <= w_beat_nxt;
    end
  end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_stall   <= w_stall_nxt;
      r_timeout <= w_tmo_nxt;
    end
  end
`endif

endmodule

`default_nettype wire
